axi_lite_sram_slave: RTL and testbench
======================================

Name: axi_lite_sram_slave

Overview:
- AXI4-Lite responder: a word-addressed SRAM model that serves the IFU/LSU AXI4-Lite masters in the NPC core.
- Independent read and write channel FSMs, each with a programmable response latency, so masters can be stressed against slow memory.
- Sits on the far side of the AXI4_Lite bus, behind the arbiter or attached directly to a single master.
- All handshakes follow AXI valid/ready rules; a transfer fires on the cycle where valid and ready are both high.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH, 65536, number of 32-bit words.
- RD_LAT, 2, extra wait cycles between AR accept and rvalid (0 allowed).
- WR_LAT, 2, extra wait cycles between AW+W captured and bvalid (0 allowed).
- INIT_FILE, "", hex image loaded with $readmemh at time 0 when non-empty.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- araddr  in  32  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  master ready for read data.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  master ready for write response.

Behaviour:
- Address decode: idx = (addr - ADDR_BASE) >> 2; addr[1:0] ignored. In range iff ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH; otherwise SLVERR.
- Reset, entered asynchronously while rst=0:
  - both FSMs go to idle; arready=1, awready=1, wready=1.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; latency counters cleared.
  - memory array is not cleared.
  - a reset mid-transaction drops the transaction with no response; a write whose commit edge has not yet occurred is not performed.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On AR fire, latch araddr and load counter with RD_LAT. Go to R_WAIT if RD_LAT>0, else R_RESP.
  - R_WAIT: arready=0; counter decrements each cycle; at 1, go to R_RESP.
  - Data is sampled from the array on the edge entering R_RESP; out-of-range returns rdata=0, rresp=2'b10.
  - Timing: AR fire at edge T gives rvalid=1 from edge T+1+RD_LAT.
  - R_RESP: rvalid=1; rdata and rresp held stable until R fire, then R_IDLE (arready=1 the next cycle). There is no back-to-back AR in the R fire cycle.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: awready=1 until AW is captured, wready=1 until W is captured. AW and W are accepted in either order or in the same cycle; each ready drops the cycle after its own capture.
  - When both are held, load counter with WR_LAT; go to W_WAIT, or directly to W_RESP if WR_LAT=0.
  - Commit happens on the edge entering W_RESP: for each i with wstrb[i]=1, update byte i of mem[idx]. Out-of-range writes are dropped with bresp=2'b10. wstrb=0 is an OKAY no-op.
  - W_RESP: bvalid=1; held stable until B fire, then W_IDLE.
- Read/write concurrency: channels are fully independent. If a read sample and a write commit hit the same word on the same edge, the read returns pre-write data.

Test Plan:
- Reset with rst=0, then release -> arready=awready=wready=1, rvalid=bvalid=0; assert rst=0 again mid-R_WAIT -> rvalid stays 0, arready=1 immediately.
- RD_LAT=2, INIT_FILE word0=32'h0000_0413; AR 32'h8000_0000 fired at cycle 0 with rready=1 -> rvalid at cycle 3, rdata=32'h0000_0413, rresp=0, arready=1 at cycle 4.
- W fired 2 cycles before AW, wdata=32'hAABB_CCDD, wstrb=4'b0101, addr 32'h8000_0010, old word 32'h1122_3344 -> bvalid at AW+1+WR_LAT; a readback returns 32'h11BB_33DD.
- rready held low 5 cycles during R_RESP -> rvalid, rdata, rresp unchanged; arready=0 throughout.
- Read of 32'h7FFF_FFFC and write to ADDR_BASE+4*DEPTH -> rresp=2'b10 with rdata=0, bresp=2'b10, memory unchanged.
- RD_LAT=WR_LAT=0, read and write to the same word fired on the same cycle (old 32'h0, new 32'hFFFF_FFFF, wstrb=4'hF) -> read returns 32'h0 at the next cycle; a subsequent read returns 32'hFFFF_FFFF.

Source files
------------

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite word-addressed SRAM responder with programmable read/write latency.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_WAIT | read latency down-counter running
// R_RESP | rvalid high, rdata/rresp held until the master takes them
// W_IDLE | awready/wready high until each half of the write is captured
// W_WAIT | write latency down-counter running, both halves held
// W_RESP | write committed, bvalid high until the master takes it
module axi_lite_sram_slave #(
   parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
   parameter int unsigned DEPTH     = 65536,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned WR_LAT    = 2,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam logic [15:0] RD_LAT_W = 16'(RD_LAT);
   localparam logic [15:0] WR_LAT_W = 16'(WR_LAT);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

   logic [31:0] mem [DEPTH];

   // Offset computed without forming ADDR_BASE + 4*DEPTH, which could wrap.
   function automatic logic in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - ADDR_BASE;
      return (a >= ADDR_BASE) && ({2'b00, off[31:2]} < DEPTH_W);
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - ADDR_BASE;
      return off[IW+1:2];
   endfunction

   r_state_t    r_state_q, r_state_d;
   logic [15:0] r_cnt_q, r_cnt_d;
   logic [31:0] raddr_q, raddr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        r_sample;
   logic [31:0] r_sample_addr;

   w_state_t    w_state_q, w_state_d;
   logic [15:0] w_cnt_q, w_cnt_d;
   logic        aw_held_q, aw_held_d;
   logic        w_held_q, w_held_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        w_commit;
   logic        mem_we;
   logic [IW-1:0] w_idx;

   // Read channel next-state; the array is sampled on the edge entering R_RESP.
   always_comb begin
      r_state_d     = r_state_q;
      r_cnt_d       = r_cnt_q;
      raddr_d       = raddr_q;
      rdata_d       = rdata_q;
      rresp_d       = rresp_q;
      r_sample      = 1'b0;
      r_sample_addr = raddr_q;
      case (r_state_q)
         R_IDLE: begin
            if (arvalid) begin
               raddr_d = araddr;
               r_cnt_d = RD_LAT_W;
               if (RD_LAT_W == 16'd0) begin
                  r_state_d     = R_RESP;
                  r_sample      = 1'b1;
                  r_sample_addr = araddr;
               end else begin
                  r_state_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            r_cnt_d = r_cnt_q - 16'd1;
            if (r_cnt_q <= 16'd1) begin
               r_state_d = R_RESP;
               r_sample  = 1'b1;
            end
         end
         R_RESP: begin
            if (rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
      if (r_sample) begin
         if (in_range(r_sample_addr)) begin
            rdata_d = mem[word_idx(r_sample_addr)];
            rresp_d = RESP_OKAY;
         end else begin
            rdata_d = 32'd0;
            rresp_d = RESP_SLVERR;
         end
      end
   end

   // Read channel registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state_q <= R_IDLE;
         r_cnt_q   <= 16'd0;
         raddr_q   <= 32'd0;
         rdata_q   <= 32'd0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         r_cnt_q   <= r_cnt_d;
         raddr_q   <= raddr_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Write channel next-state; AW and W captured independently, commit on entry to W_RESP.
   always_comb begin
      w_state_d = w_state_q;
      w_cnt_d   = w_cnt_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      w_commit  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (awvalid && !aw_held_q) begin
               waddr_d   = awaddr;
               aw_held_d = 1'b1;
            end
            if (wvalid && !w_held_q) begin
               wdata_d  = wdata;
               wstrb_d  = wstrb;
               w_held_d = 1'b1;
            end
            if (aw_held_d && w_held_d) begin
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               w_cnt_d   = WR_LAT_W;
               if (WR_LAT_W == 16'd0) begin
                  w_state_d = W_RESP;
                  w_commit  = 1'b1;
               end else begin
                  w_state_d = W_WAIT;
               end
            end
         end
         W_WAIT: begin
            w_cnt_d = w_cnt_q - 16'd1;
            if (w_cnt_q <= 16'd1) begin
               w_state_d = W_RESP;
               w_commit  = 1'b1;
            end
         end
         W_RESP: begin
            if (bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
      if (w_commit) bresp_d = in_range(waddr_d) ? RESP_OKAY : RESP_SLVERR;
   end

   assign mem_we = w_commit && in_range(waddr_d);
   assign w_idx  = word_idx(waddr_d);

   // Write channel registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state_q <= W_IDLE;
         w_cnt_q   <= 16'd0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         waddr_q   <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         w_cnt_q   <= w_cnt_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
      end
   end

   // Byte-lane commit; same-edge reads see the old word since the read side samples combinationally.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_d[i]) mem[w_idx][8*i +: 8] <= wdata_d[8*i +: 8];
         end
      end
   end

   assign arready = (r_state_q == R_IDLE);
   assign rvalid  = (r_state_q == R_RESP);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign awready = (w_state_q == W_IDLE) && !aw_held_q;
   assign wready  = (w_state_q == W_IDLE) && !w_held_q;
   assign bvalid  = (w_state_q == W_RESP);
   assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench: a 2-cycle-latency instance and a zero-latency instance share clock and reset.
module tb_axi_lite_sram_slave;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   logic [31:0] b_araddr, b_rdata, b_awaddr, b_wdata;
   logic        b_arvalid, b_arready, b_rvalid, b_rready, b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
   logic [1:0]  b_rresp, b_bresp;
   logic [3:0]  b_wstrb;

   int n_chk = 0;
   int n_err = 0;

   axi_lite_sram_slave #(.ADDR_BASE(BASE), .DEPTH(65536), .RD_LAT(2), .WR_LAT(2), .INIT_FILE("")) u_dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   axi_lite_sram_slave #(.ADDR_BASE(BASE), .DEPTH(1024), .RD_LAT(0), .WR_LAT(0), .INIT_FILE("")) u_dut0 (
      .clk(clk), .rst(rst),
      .araddr(b_araddr), .arvalid(b_arvalid), .arready(b_arready),
      .rdata(b_rdata), .rresp(b_rresp), .rvalid(b_rvalid), .rready(b_rready),
      .awaddr(b_awaddr), .awvalid(b_awvalid), .awready(b_awready),
      .wdata(b_wdata), .wstrb(b_wstrb), .wvalid(b_wvalid), .wready(b_wready),
      .bresp(b_bresp), .bvalid(b_bvalid), .bready(b_bready)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      int n;
      n = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      step();
      arvalid = 1'b0;
      while (!rvalid && n < 20) begin step(); n++; end
      chk_eq("a_rd_rvalid", 32'(rvalid), 32'd1);
      d = rdata; r = rresp;
      step();
      rready = 1'b0;
   endtask

   task automatic a_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
      int n;
      n = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      while (!bvalid && n < 20) begin step(); n++; end
      chk_eq("a_wr_bvalid", 32'(bvalid), 32'd1);
      r = bresp;
      step();
      bready = 1'b0;
   endtask

   task automatic b_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      int n;
      n = 0;
      b_araddr = a; b_arvalid = 1'b1; b_rready = 1'b1;
      step();
      b_arvalid = 1'b0;
      while (!b_rvalid && n < 20) begin step(); n++; end
      chk_eq("b_rd_rvalid", 32'(b_rvalid), 32'd1);
      d = b_rdata; r = b_rresp;
      step();
      b_rready = 1'b0;
   endtask

   task automatic b_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
      int n;
      n = 0;
      b_awaddr = a; b_wdata = d; b_wstrb = s; b_awvalid = 1'b1; b_wvalid = 1'b1; b_bready = 1'b1;
      step();
      b_awvalid = 1'b0; b_wvalid = 1'b0;
      while (!b_bvalid && n < 20) begin step(); n++; end
      chk_eq("b_wr_bvalid", 32'(b_bvalid), 32'd1);
      r = b_bresp;
      step();
      b_bready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          n;

      rst = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      b_araddr = '0; b_arvalid = 1'b0; b_rready = 1'b0;
      b_awaddr = '0; b_awvalid = 1'b0; b_wdata = '0; b_wstrb = '0; b_wvalid = 1'b0; b_bready = 1'b0;

      // Reset values
      repeat (3) step();
      chk_eq("rst_arready", 32'(arready), 32'd1);
      chk_eq("rst_awready", 32'(awready), 32'd1);
      chk_eq("rst_wready",  32'(wready),  32'd1);
      chk_eq("rst_rvalid",  32'(rvalid),  32'd0);
      chk_eq("rst_bvalid",  32'(bvalid),  32'd0);
      chk_eq("rst_rdata",   rdata,        32'd0);
      chk_eq("rst_b_arready", 32'(b_arready), 32'd1);
      rst = 1'b1;
      step();

      // Preload
      a_wr(BASE, 32'h0000_0413, 4'hF, r);
      chk_eq("pre0_bresp", 32'(r), 32'd0);
      a_wr(BASE + 32'h10, 32'h1122_3344, 4'hF, r);
      chk_eq("pre1_bresp", 32'(r), 32'd0);

      // Read latency: AR in cycle 0 -> rvalid in cycle 3, arready back in cycle 4
      araddr = BASE; arvalid = 1'b1; rready = 1'b1;
      chk_eq("rt_arready_c0", 32'(arready), 32'd1);
      step();
      arvalid = 1'b0;
      chk_eq("rt_rvalid_c1", 32'(rvalid), 32'd0);
      chk_eq("rt_arready_c1", 32'(arready), 32'd0);
      step();
      chk_eq("rt_rvalid_c2", 32'(rvalid), 32'd0);
      step();
      chk_eq("rt_rvalid_c3", 32'(rvalid), 32'd1);
      chk_eq("rt_rdata_c3", rdata, 32'h0000_0413);
      chk_eq("rt_rresp_c3", 32'(rresp), 32'd0);
      step();
      chk_eq("rt_rvalid_c4", 32'(rvalid), 32'd0);
      chk_eq("rt_arready_c4", 32'(arready), 32'd1);
      rready = 1'b0;

      // W two cycles before AW, partial strobes
      wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
      chk_eq("wf_wready_c0", 32'(wready), 32'd1);
      step();
      wvalid = 1'b0;
      chk_eq("wf_wready_c1", 32'(wready), 32'd0);
      chk_eq("wf_awready_c1", 32'(awready), 32'd1);
      chk_eq("wf_bvalid_c1", 32'(bvalid), 32'd0);
      step();
      awaddr = BASE + 32'h10; awvalid = 1'b1; bready = 1'b1;
      step();
      awvalid = 1'b0;
      chk_eq("wf_awready_c3", 32'(awready), 32'd0);
      chk_eq("wf_bvalid_c3", 32'(bvalid), 32'd0);
      step();
      chk_eq("wf_bvalid_c4", 32'(bvalid), 32'd0);
      step();
      chk_eq("wf_bvalid_c5", 32'(bvalid), 32'd1);
      chk_eq("wf_bresp_c5", 32'(bresp), 32'd0);
      step();
      chk_eq("wf_bvalid_c6", 32'(bvalid), 32'd0);
      chk_eq("wf_awready_c6", 32'(awready), 32'd1);
      chk_eq("wf_wready_c6", 32'(wready), 32'd1);
      bready = 1'b0;
      a_rd(BASE + 32'h10, d, r);
      chk_eq("wf_readback", d, 32'h11BB_33DD);

      // rready stall for 5 cycles
      araddr = BASE; arvalid = 1'b1; rready = 1'b0;
      step();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin step(); n++; end
      for (int i = 0; i < 5; i++) begin
         chk_eq("st_rvalid", 32'(rvalid), 32'd1);
         chk_eq("st_rdata", rdata, 32'h0000_0413);
         chk_eq("st_rresp", 32'(rresp), 32'd0);
         chk_eq("st_arready", 32'(arready), 32'd0);
         step();
      end
      rready = 1'b1;
      chk_eq("st_rvalid_last", 32'(rvalid), 32'd1);
      step();
      chk_eq("st_rvalid_done", 32'(rvalid), 32'd0);
      chk_eq("st_arready_done", 32'(arready), 32'd1);
      rready = 1'b0;

      // Address range boundaries
      a_rd(32'h7FFF_FFFC, d, r);
      chk_eq("oor_rd_rdata", d, 32'd0);
      chk_eq("oor_rd_rresp", 32'(r), 32'd2);
      a_wr(BASE + 32'h0004_0000, 32'hDEAD_BEEF, 4'hF, r);
      chk_eq("oor_wr_bresp", 32'(r), 32'd2);
      a_rd(BASE, d, r);
      chk_eq("oor_wr_nochange", d, 32'h0000_0413);
      chk_eq("oor_wr_nochange_resp", 32'(r), 32'd0);
      a_rd(BASE + 32'h0004_0000, d, r);
      chk_eq("oor_rd_top_rresp", 32'(r), 32'd2);
      a_wr(BASE + 32'h0003_FFFC, 32'h5A5A_0001, 4'hF, r);
      chk_eq("last_wr_bresp", 32'(r), 32'd0);
      a_rd(BASE + 32'h0003_FFFC, d, r);
      chk_eq("last_rd_rdata", d, 32'h5A5A_0001);
      a_wr(BASE, 32'hFFFF_FFFF, 4'h0, r);
      chk_eq("strb0_bresp", 32'(r), 32'd0);
      a_rd(BASE, d, r);
      chk_eq("strb0_nochange", d, 32'h0000_0413);

      // Zero latency instance: same-word read and write on one edge
      b_wr(BASE + 32'h40, 32'h0000_0000, 4'hF, r);
      chk_eq("b_pre_bresp", 32'(r), 32'd0);
      b_araddr = BASE + 32'h40; b_arvalid = 1'b1; b_rready = 1'b1;
      b_awaddr = BASE + 32'h40; b_awvalid = 1'b1; b_wdata = 32'hFFFF_FFFF; b_wstrb = 4'hF;
      b_wvalid = 1'b1; b_bready = 1'b1;
      step();
      b_arvalid = 1'b0; b_awvalid = 1'b0; b_wvalid = 1'b0;
      chk_eq("b_same_rvalid", 32'(b_rvalid), 32'd1);
      chk_eq("b_same_rdata", b_rdata, 32'h0000_0000);
      chk_eq("b_same_rresp", 32'(b_rresp), 32'd0);
      chk_eq("b_same_bvalid", 32'(b_bvalid), 32'd1);
      chk_eq("b_same_bresp", 32'(b_bresp), 32'd0);
      step();
      chk_eq("b_same_rvalid_done", 32'(b_rvalid), 32'd0);
      chk_eq("b_same_bvalid_done", 32'(b_bvalid), 32'd0);
      b_rready = 1'b0; b_bready = 1'b0;
      b_rd(BASE + 32'h40, d, r);
      chk_eq("b_after_rdata", d, 32'hFFFF_FFFF);
      b_rd(BASE + 32'h1000, d, r);
      chk_eq("b_oor_rresp", 32'(r), 32'd2);

      // Reset during R_WAIT drops the read
      araddr = BASE; arvalid = 1'b1; rready = 1'b1;
      step();
      arvalid = 1'b0;
      chk_eq("rr_arready_wait", 32'(arready), 32'd0);
      rst = 1'b0;
      #1;
      chk_eq("rr_arready_rst", 32'(arready), 32'd1);
      chk_eq("rr_rvalid_rst", 32'(rvalid), 32'd0);
      repeat (2) step();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_eq("rr_rvalid_after", 32'(rvalid), 32'd0);
      end
      rready = 1'b0;

      // Reset during W_WAIT drops the write before its commit edge
      a_wr(BASE + 32'h20, 32'h1234_5678, 4'hF, r);
      awaddr = BASE + 32'h20; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      chk_eq("wr_awready_wait", 32'(awready), 32'd0);
      rst = 1'b0;
      #1;
      chk_eq("wr_awready_rst", 32'(awready), 32'd1);
      chk_eq("wr_wready_rst", 32'(wready), 32'd1);
      chk_eq("wr_bvalid_rst", 32'(bvalid), 32'd0);
      repeat (3) step();
      rst = 1'b1;
      repeat (3) step();
      chk_eq("wr_bvalid_after", 32'(bvalid), 32'd0);
      bready = 1'b0;
      a_rd(BASE + 32'h20, d, r);
      chk_eq("wr_dropped_data", d, 32'h1234_5678);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
